// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among M requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_FLAGS_EN to register alu_flags into rsp_flags; otherwise rsp_flags is tied to zero.
module alu_arbiter #(
  parameter int N = 24,
  parameter int M = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M-1:0]           req_valid,
  output logic [M-1:0]           req_ready,
  input  logic [M*N-1:0]         req_A,
  input  logic [M*N-1:0]         req_B,
  input  logic [M*3-1:0]         req_ctrl,
  output logic [N-1:0]           alu_A,
  output logic [N-1:0]           alu_B,
  output logic [2:0]             alu_ctrl,
  input  logic [N-1:0]           alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(M)-1:0]   rsp_id,
  output logic [N-1:0]           rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   busy
);

  localparam int IW = $clog2(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   last_grant_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [2:0]      ctrl_q;
  logic [IW-1:0]   id_q;
  logic [N-1:0]    rsp_result_q;
  logic [IW-1:0]   rsp_id_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            grant_any;
  logic [IW-1:0]   grant_idx;

`ifdef ALU_ARBITER_FLAGS_EN
  logic [3:0]      flags_q;
`endif

  // Round-robin search: first valid requester after last_grant, wrapping modulo M.
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= M; k++) begin
      cand = (int'(last_grant_q) + k) % M;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IW'(cand);
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Grant is offered only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Control FSM with latched operands and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(M - 1);
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= 3'b000;
      id_q         <= '0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
      flags_q      <= 4'b0000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q          <= req_A[int'(grant_idx)*N +: N];
            b_q          <= req_B[int'(grant_idx)*N +: N];
            ctrl_q       <= req_ctrl[int'(grant_idx)*3 +: 3];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= EXEC;
            busy_q       <= 1'b1;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_id_q     <= id_q;
`ifdef ALU_ARBITER_FLAGS_EN
          flags_q      <= alu_flags;
`endif
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= RESP;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // ALU inputs come straight from the latched operands so they stay quiet outside EXEC.
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

`ifdef ALU_ARBITER_FLAGS_EN
  assign rsp_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign rsp_flags    = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

  localparam int N = 24;
  localparam int M = 4;

  logic           clk;
  logic           rst;
  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_ready;
  logic [M*N-1:0] req_A;
  logic [M*N-1:0] req_B;
  logic [M*3-1:0] req_ctrl;
  logic [N-1:0]   alu_A;
  logic [N-1:0]   alu_B;
  logic [2:0]     alu_ctrl;
  logic [N-1:0]   alu_result;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           busy;

  typedef struct {
    logic [1:0]  id;
    logic [23:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_arbiter #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_ctrl   (req_ctrl),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  // Shared ALU: {N,Z,C,V} flags plus result; shifts use B[7:3] as the amount.
  function automatic logic [27:0] alu_model(input logic [23:0] a, input logic [23:0] b,
                                            input logic [2:0] c);
    logic [24:0] t;
    logic [23:0] r;
    logic        cf;
    logic        vf;
    t  = 25'd0;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      3'b000: begin t = {1'b0, a} + {1'b0, b}; r = t[23:0]; cf = t[24];
                    vf = (a[23] == b[23]) && (r[23] != a[23]); end
      3'b001: begin t = {1'b0, a} - {1'b0, b}; r = t[23:0]; cf = t[24];
                    vf = (a[23] != b[23]) && (r[23] != a[23]); end
      3'b010: r = a * b;
      3'b011: r = a << b[7:3];
      3'b111: r = a >> b[7:3];
      default: r = a ^ b;
    endcase
    return {r[23], (r == 24'd0), cf, vf, r};
  endfunction

  assign {alu_flags, alu_result} = alu_model(alu_A, alu_B, alu_ctrl);

  function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef ALU_ARBITER_FLAGS_EN
    return f;
`else
    return (f & 4'b0000);
`endif
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b,
                         input logic [2:0] c);
    req_A[i*N +: N]  = a;
    req_B[i*N +: N]  = b;
    req_ctrl[i*3 +: 3] = c;
  endtask

  task automatic push(input logic [1:0] id, input logic [23:0] res, input logic [3:0] f);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.fl  = f;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_sb"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, e.id});
      chk({tag, "_res"}, {8'd0, rsp_result}, {8'd0, e.res});
      chk({tag, "_flags"}, {28'd0, rsp_flags}, {28'd0, e.fl});
    end
  endtask

  // Accept the currently offered request and run it through EXEC and RESP.
  task automatic run_one(input string tag);
    step();
    req_valid = 4'b0000;
    step();
    pop_check(tag);
    step();
  endtask

  initial begin
    logic [3:0] oh;
    logic [23:0] stream_res [4];
    stream_res = '{24'd30, 24'd42, 24'd42, 24'd8};

    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_A     = '0;
    req_B     = '0;
    req_ctrl  = '0;
    step();
    step();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {8'd0, rsp_result}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_aluA", {8'd0, alu_A}, 32'd0);
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single add request from requester 0.
    set_req(0, 24'd5, 24'd7, 3'b000);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", {28'd0, req_ready}, 32'h1);
    push(2'd0, 24'd12, fl(4'b0000));
    step();
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_novalid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_noready", {28'd0, req_ready}, 32'd0);
    chk("exec_aluA", {8'd0, alu_A}, 32'd5);
    chk("exec_aluB", {8'd0, alu_B}, 32'd7);
    chk("exec_ctrl", {29'd0, alu_ctrl}, 32'd0);
    req_valid = 4'b0000;
    step();
    pop_check("single");
    chk("resp_aluA_held", {8'd0, alu_A}, 32'd5);
    step();
    chk("idle_novalid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Fresh reset, then all four requesters valid continuously.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 24'd10, 24'd20, 3'b000);
    set_req(1, 24'd50, 24'd8, 3'b001);
    set_req(2, 24'd6, 24'd7, 3'b010);
    set_req(3, 24'd1, 24'h18, 3'b011);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      push(2'(k % 4), stream_res[k % 4], fl(4'b0000));
      chk("rr_grant", {28'd0, req_ready}, {28'd0, oh});
      step();
      chk("rr_exec_busy", {31'd0, busy}, 32'd1);
      step();
      pop_check("rr");
      step();
    end
    req_valid = 4'b0000;

    // Backpressure on a sub that yields zero.
    set_req(1, 24'd3, 24'd3, 3'b001);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h2);
    push(2'd1, 24'd0, fl(4'b0100));
    step();
    req_valid = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", {8'd0, rsp_result}, 32'd0);
      chk("bp_id", {30'd0, rsp_id}, 32'd1);
      chk("bp_flags", {28'd0, rsp_flags}, {28'd0, fl(4'b0100)});
      chk("bp_noready", {28'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    pop_check("bp");
    step();
    chk("bp_next_grant", {28'd0, req_ready}, 32'h4);
    req_valid = 4'b0000;

    // Reset while requester 2 is in EXEC.
    req_valid = 4'b0100;
    #1;
    chk("rx_grant", {28'd0, req_ready}, 32'h4);
    step();
    chk("rx_exec_busy", {31'd0, busy}, 32'd1);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("rx_busy", {31'd0, busy}, 32'd0);
    chk("rx_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rx_ready", {28'd0, req_ready}, 32'd0);
    step();
    rst = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 4'b1111;
    #1;
    chk("rx_after_grant", {28'd0, req_ready}, 32'h1);
    push(2'd0, 24'd30, fl(4'b0000));
    run_one("rx_after");

    // Serve requester 3 alone, then wrap to requester 0 with an srl.
    req_valid = 4'b1000;
    #1;
    chk("w3_grant", {28'd0, req_ready}, 32'h8);
    push(2'd3, 24'd8, fl(4'b0000));
    run_one("w3");
    set_req(0, 24'h000100, 24'h000020, 3'b111);
    req_valid = 4'b1001;
    #1;
    chk("wrap_grant", {28'd0, req_ready}, 32'h1);
    push(2'd0, 24'h000010, fl(4'b0000));
    run_one("wrap_srl");

    // Underflowing sub.
    set_req(0, 24'd1, 24'd2, 3'b001);
    req_valid = 4'b0001;
    #1;
    chk("neg_grant", {28'd0, req_ready}, 32'h1);
    push(2'd0, 24'hFFFFFF, fl(4'b1010));
    run_one("neg_sub");

    // A request withdrawn before any edge is neither served nor counted.
    req_valid = 4'b0010;
    #1;
    chk("wd_offer", {28'd0, req_ready}, 32'h2);
    req_valid = 4'b0000;
    step();
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_valid", {31'd0, rsp_valid}, 32'd0);

    // Undefined ctrl code passes through to the ALU.
    set_req(1, 24'hF0F0F0, 24'h0F0F00, 3'b101);
    req_valid = 4'b0011;
    #1;
    chk("undef_grant", {28'd0, req_ready}, 32'h2);
    push(2'd1, 24'hFFFFF0, fl(4'b1000));
    step();
    req_valid = 4'b0000;
    chk("undef_ctrl", {29'd0, alu_ctrl}, 32'h5);
    step();
    pop_check("undef");
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 24, meaning operand/result width.
REQ-002 SHALL have parameter M, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  M  per-requester operation request.
REQ-006 SHALL have port req_ready  output  M  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_A  input  M*N  packed A operands; requester i occupies bits [i*N +: N].
REQ-008 SHALL have port req_B  input  M*N  packed B operands, packed the same way.
REQ-009 SHALL have port req_ctrl  input  M*3  packed 3-bit ALUControl codes (000 add, 001 sub, 010 mult, 011 sll, 111 srl).
REQ-010 SHALL have port alu_A / alu_B  output  N each  operands driven to the shared combinational ALU.
REQ-011 SHALL have port alu_ctrl  output  3  ALUControl driven to the shared ALU.
REQ-012 SHALL have port alu_result  input  N  shared ALU result.
REQ-013 SHALL have port alu_flags  input  4  shared ALU flags {N,Z,C,V}.
REQ-014 SHALL have port rsp_valid  output  1  response holding.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port rsp_id  output  $clog2(M)  index of the requester owning the response.
REQ-017 SHALL have port rsp_result  output  N  registered result.
REQ-018 SHALL have port rsp_flags  output  4  registered flags.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-021 In IDLE with any req_valid high, SHALL assert req_ready for exactly one requester, chosen round-robin starting at last_grant+1 modulo M; on that edge it latches that requester's A, B, ctrl and index and moves to EXEC.
REQ-022 SHALL drive req_ready only in IDLE, and combinationally from req_valid and last_grant.
REQ-023 SHALL update last_grant only on an accepted request.
REQ-024 In EXEC, SHALL drive alu_A/alu_B/alu_ctrl from the latched operands, capture alu_result, alu_flags and the index into the rsp registers, and move to RESP.
REQ-025 In RESP, SHALL hold rsp_valid=1 with all rsp_* outputs stable until rsp_ready=1; on that edge it clears rsp_valid and returns to IDLE.
REQ-026 Accept-to-rsp_valid latency SHALL be 2 cycles; maximum throughput SHALL be one operation per 3 cycles; no accept occurs in EXEC or RESP.
REQ-027 SHALL keep alu_* outputs at the latched values outside EXEC, so they do not toggle on unselected requests.
REQ-028 SHALL pass undefined ctrl codes (100/101/110) through unchanged, so the response carries whatever the ALU returns.
REQ-029 A requester whose valid drops before its grant SHALL NOT be served and SHALL NOT alter last_grant.

Reset
REQ-030 rst=1 SHALL force state=IDLE, last_grant=M-1 (requester 0 wins first), and latched operands, rsp_result, rsp_flags and rsp_id to 0, with rsp_valid=0, busy=0 and req_ready=0 while asserted.
REQ-031 rst during EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-032 With macro ALU_ARBITER_FLAGS_EN defined, SHALL register alu_flags into rsp_flags per REQ-024.
REQ-033 Without ALU_ARBITER_FLAGS_EN, rsp_flags SHALL be constant 4'b0000 and no flag register SHALL exist.

Verification
REQ-034 Single request: req0 add A=5, B=7, rsp_ready=1 -> rsp_valid 2 cycles after accept with rsp_result=12, rsp_id=0, flags 0000.
REQ-035 All four valid continuously with rsp_ready=1 -> grants 0,1,2,3,0 in order, one every 3 cycles.
REQ-036 Backpressure: req1 sub A=3, B=3 with rsp_ready=0 for 5 cycles -> rsp_result=0 and Z=1 held stable, req_ready all 0 until rsp_ready=1.
REQ-037 Reset in EXEC: req2 mult, rst pulsed on the EXEC cycle -> no rsp_valid, next grant goes to requester 0.
REQ-038 Wrap: last_grant=3, req3 and req0 valid -> req0 granted; srl A=0x000100 with B[7:3]=4 -> rsp_result=0x000010.
REQ-039 Build without ALU_ARBITER_FLAGS_EN: sub 1-2 -> rsp_result=0xFFFFFF, rsp_flags=0000.
